dmem_word_reader: RTL and testbench

- Sequential read-side companion to the byte-lane data memory (four 8-bit lanes, byte0 = LSB).
- Memory is preloaded by writes. This block is the reader: on `start` it walks a word-address range and reassembles each word from the four lanes.
- Streams each word out over a valid/ready handshake and keeps a running checksum.
- Used for end-of-run memory dumps and self-checking in CPU benches.

---
 rtl/dmem_word_reader.sv | 129 ++++++++++++
 tb/tb_dmem_word_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_word_reader.sv
// Sequential reader for the four-lane byte memory: walks a word-address range,
// streams each reassembled word over valid/ready and accumulates a checksum.
module dmem_word_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           checksum,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata_b0,
    input  logic [7:0]            mem_rdata_b1,
    input  logic [7:0]            mem_rdata_b2,
    input  logic [7:0]            mem_rdata_b3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_CAPT = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [31:0]           checksum_q, checksum_d;
    logic [31:0]           out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;

    logic [7:0]  lane [4];
    logic [31:0] rd_word;

    assign lane[0] = mem_rdata_b0;
    assign lane[1] = mem_rdata_b1;
    assign lane[2] = mem_rdata_b2;
    assign lane[3] = mem_rdata_b3;

    // Lane 0 is the least significant byte of the reassembled word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_word[gi*8 +: 8] = lane[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        checksum_d  = checksum_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        done_d      = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d  = base_addr;
                    remaining_d = word_count;
                    checksum_d  = '0;
                    state_d     = (word_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: state_d = S_CAPT;
            S_CAPT: begin
                out_data_d  = rd_word;
                out_addr_d  = cur_addr_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    checksum_d  = checksum_q + out_data_q;
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                    out_valid_d = 1'b0;
                    state_d     = (remaining_d == '0) ? S_DONE : S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            checksum_q  <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            checksum_q  <= checksum_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign checksum  = checksum_q;
    assign mem_rd_en = (state_q == S_READ);
    assign mem_addr  = cur_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_dmem_word_reader.sv
// Randomized bench for dmem_word_reader against a word-list/sum reference model.
module tb_dmem_word_reader;

    localparam int AW = 8;
    localparam int CW = 9;

    logic          CLK = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic          busy, done, mem_rd_en, out_valid, out_ready;
    logic [31:0]   checksum, out_data;
    logic [AW-1:0] mem_addr, out_addr;
    logic [7:0]    mem_rdata_b0, mem_rdata_b1, mem_rdata_b2, mem_rdata_b3;

    always #5 CLK = ~CLK;

    dmem_word_reader #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .checksum(checksum), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata_b0(mem_rdata_b0), .mem_rdata_b1(mem_rdata_b1),
        .mem_rdata_b2(mem_rdata_b2), .mem_rdata_b3(mem_rdata_b3),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
    );

    logic [7:0]    mem [4][256];
    logic [AW-1:0] exp_addr_q [$];
    logic [31:0]   exp_data_q [$];
    logic [31:0]   exp_sum;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            rd_cnt = 0;
    int            hs_cnt = 0;
    int            ready_mode = 0;
    int            stall_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        return {mem[3][a], mem[2][a], mem[1][a], mem[0][a]};
    endfunction

    // Memory: read data appears the cycle after a read strobe, garbage otherwise.
    initial begin
        logic          en;
        logic [AW-1:0] a;
        {mem_rdata_b3, mem_rdata_b2, mem_rdata_b1, mem_rdata_b0} = '0;
        forever begin
            @(negedge CLK);
            en = mem_rd_en;
            a  = mem_addr;
            @(posedge CLK);
            #1;
            if (en) {mem_rdata_b3, mem_rdata_b2, mem_rdata_b1, mem_rdata_b0} = word_at(a);
            else    {mem_rdata_b3, mem_rdata_b2, mem_rdata_b1, mem_rdata_b0} = $urandom;
        end
    end

    // Consumer: chooses out_ready for the next edge, then checks what that edge accepts.
    initial begin
        logic          prev_hold;
        logic [31:0]   prev_data;
        logic [AW-1:0] prev_addr;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_addr = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge CLK);
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && stall_cnt < 5) begin
                        stall_cnt++;
                        out_ready = 1'b0;
                    end else begin
                        out_ready = (stall_cnt >= 5);
                    end
                end
            endcase
            if (rst) begin
                if (mem_rd_en) begin
                    rd_cnt++;
                    check("rd_while_valid", out_valid, 0);
                end
                if (prev_hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, prev_data);
                    check("hold_addr", out_addr, prev_addr);
                end
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (exp_addr_q.size() == 0) begin
                        check("extra_word", 1, 0);
                    end else begin
                        check("word_addr", out_addr, exp_addr_q.pop_front());
                        check("word_data", out_data, exp_data_q.pop_front());
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_data = out_data;
                prev_addr = out_addr;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic load_expect(input logic [AW-1:0] base, input logic [CW-1:0] cnt);
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_sum = '0;
        for (int i = 0; i < int'(cnt); i++) begin
            logic [AW-1:0] a;
            a = base + AW'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(word_at(a));
            exp_sum = exp_sum + word_at(a);
        end
        rd_cnt    = 0;
        hs_cnt    = 0;
        stall_cnt = 0;
    endtask

    task automatic run_xfer(input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                            input int mode, input bit noise, input bit timing);
        int k;
        int fv;
        int budget;
        load_expect(base, cnt);
        ready_mode = mode;
        budget     = 20 * int'(cnt) + 50;
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        @(negedge CLK);
        start = 1'b0;
        k  = 1;
        fv = 0;
        check("busy_rise", busy, 1);
        while (!done && k < budget) begin
            if (out_valid && fv == 0) fv = k;
            start = noise && busy && ($urandom_range(0, 2) == 0);
            if (start) begin
                base_addr  = AW'($urandom);
                word_count = CW'($urandom);
            end
            @(negedge CLK);
            start = 1'b0;
            k++;
        end
        check("done_seen", done, 1);
        check("done_checksum", checksum, exp_sum);
        check("busy_at_done", busy, 0);
        if (timing) begin
            check("done_latency", k, 3 * int'(cnt) + 2);
            if (cnt != 0) check("first_valid_latency", fv, 3);
        end
        @(negedge CLK);
        check("done_one_cycle", done, 0);
        check("checksum_stable", checksum, exp_sum);
        check("words_left", exp_addr_q.size(), 0);
        check("rd_count", rd_cnt, cnt);
        check("hs_count", hs_cnt, cnt);
        $display("xfer base=%0h count=%0d mode=%0d cycles=%0d checksum=%08h", base, cnt, mode, k, checksum);
    endtask

    initial begin
        int k;
        rst        = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        for (int l = 0; l < 4; l++)
            for (int a = 0; a < 256; a++)
                mem[l][a] = 8'($urandom);
        {mem[3][0], mem[2][0], mem[1][0], mem[0][0]} = {8'h56, 8'h78, 8'h34, 8'h12};
        {mem[3][1], mem[2][1], mem[1][1], mem[0][1]} = {8'h9A, 8'hBC, 8'hDE, 8'hF0};

        repeat (3) @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_checksum", checksum, 0);
        rst = 1'b1;
        @(negedge CLK);

        run_xfer(8'h00, 9'd2, 0, 0, 1);
        check("tp_checksum", checksum, 32'h56783412 + 32'h9ABCDEF0);
        run_xfer(8'h00, 9'd2, 2, 0, 0);
        run_xfer(8'hFF, 9'd2, 0, 0, 1);
        run_xfer(8'h00, 9'd0, 0, 0, 1);

        // Abort while a word sits stalled on the output.
        load_expect(8'h10, 9'd3);
        ready_mode = 2;
        start      = 1'b1;
        base_addr  = 8'h10;
        word_count = 9'd3;
        @(negedge CLK);
        start = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge CLK);
            k++;
        end
        check("abort_reached_out", out_valid, 1);
        @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rd_en", mem_rd_en, 0);
        check("abort_valid", out_valid, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_addr", out_addr, 0);
        check("abort_checksum", checksum, 0);
        @(negedge CLK);
        rst = 1'b1;
        ready_mode = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("post_abort_quiet", {busy, done, out_valid}, 3'b000);
        end
        $display("xfer abort base=10 count=3");
        run_xfer(8'h05, 9'd3, 0, 0, 1);

        run_xfer(8'($urandom), 9'd4, 0, 1, 1);
        for (int t = 0; t < 8; t++)
            run_xfer(8'($urandom), 9'($urandom_range(1, 40)), 1, 1'($urandom_range(0, 1)), 0);
        run_xfer(8'h80, 9'd300, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
